// File: rtl/residu.sv
// ---------------------------------------------------------------------------
// residu -- LPC residual filter for one subframe (G.729 fixed point)
//
// Computes, for i = 0..L-1:
//     y[i] = round(L_shl(sum_{j=0..M} a[j]*x[i-j], 3))
// Coefficients, input samples (with M samples of history) and outputs share
// one external word memory. Multiply-accumulate is done by an external
// saturating L_mac (C + 2*A*B), so each tap costs three cycles:
// fetch a[j], fetch x[i-j], accumulate. Each sample then adds one cycle to
// scale/round and one cycle to write.
//
// Ports
//   clk           sole clock, rising edge
//   reset         asynchronous, active-low reset
//   start         level request, only looked at in IDLE
//   memIn         read data; [15:0] signed word, valid the cycle after the
//                 address is presented; [31:16] ignored
//   memReadAddr   read address (registered)
//   memWriteEn    write strobe, high only in WRITE
//   memWriteAddr  write address (registered)
//   memOut        write data, sign-extended y[i] (registered)
//   done          one-cycle completion pulse
//   L_macOutA     coefficient operand a[j]
//   L_macOutB     sample operand x[i-j]
//   L_macOutC     accumulator operand (0 on the first tap of a sample)
//   L_macIn       combinational saturating L_mac result
//
// State   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start
// RD_A    | address of a[j] on the read bus
// RD_X    | a[j] returned and captured; address of x[i-j] on the bus
// MAC     | x[i-j] returned; L_mac operands valid, acc updated at edge
// SCALE   | shift-left-3 and round acc, load write address/data
// WRITE   | one-cycle memory write of y[i]
// DONE    | one-cycle done pulse
// ---------------------------------------------------------------------------
module residu #(
    parameter int          M      = 10,
    parameter int          L      = 40,
    parameter logic [10:0] A_ADDR = 11'd0,
    parameter logic [10:0] X_ADDR = 11'd64,
    parameter logic [10:0] Y_ADDR = 11'd128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] memIn,
    output logic [10:0] memReadAddr,
    output logic        memWriteEn,
    output logic [10:0] memWriteAddr,
    output logic [31:0] memOut,
    output logic        done,
    output logic [15:0] L_macOutA,
    output logic [15:0] L_macOutB,
    output logic [31:0] L_macOutC,
    input  logic [31:0] L_macIn
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RD_A  = 3'd1;
    localparam logic [2:0] RD_X  = 3'd2;
    localparam logic [2:0] MAC   = 3'd3;
    localparam logic [2:0] SCALE = 3'd4;
    localparam logic [2:0] WRITE = 3'd5;
    localparam logic [2:0] DONE  = 3'd6;

    localparam logic [10:0] J_LAST = 11'(M);
    localparam logic [10:0] I_LAST = 11'(L - 1);

    logic [2:0]  state;
    logic [10:0] iIdx;
    logic [10:0] jIdx;
    logic [31:0] acc;
    logic [15:0] aReg;

    logic [31:0] shifted;
    logic [32:0] roundSum;
    logic [31:0] rounded;
    logic [15:0] yWord;

    // Only the low half of a memory word carries data.
    logic memInUnused;
    assign memInUnused = ^memIn[31:16];

    // L_shl(acc, 3) saturates unless the top four bits all match the sign.
    always_comb begin
        shifted = {acc[28:0], 3'b000};
        if (acc[31:28] != {4{acc[31]}}) begin
            shifted = acc[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
    end

    // Rounding adds a positive constant, so only positive overflow is possible.
    always_comb begin
        roundSum = {shifted[31], shifted} + 33'h0_0000_8000;
        rounded  = roundSum[31:0];
        if (roundSum[32] != roundSum[31]) begin
            rounded = 32'h7FFF_FFFF;
        end
        yWord = rounded[31:16];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            iIdx         <= '0;
            jIdx         <= '0;
            acc          <= '0;
            aReg         <= '0;
            memReadAddr  <= '0;
            memWriteAddr <= '0;
            memOut       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= RD_A;
                        iIdx        <= '0;
                        jIdx        <= '0;
                        acc         <= '0;
                        memReadAddr <= A_ADDR;
                    end
                end
                RD_A: begin
                    state       <= RD_X;
                    // History samples sit just below X_ADDR; the 11-bit wrap
                    // of X_ADDR + i - j reaches them naturally.
                    memReadAddr <= X_ADDR + iIdx - jIdx;
                end
                RD_X: begin
                    aReg  <= memIn[15:0];
                    state <= MAC;
                end
                MAC: begin
                    acc <= L_macIn;
                    if (jIdx < J_LAST) begin
                        jIdx        <= jIdx + 11'd1;
                        memReadAddr <= A_ADDR + jIdx + 11'd1;
                        state       <= RD_A;
                    end else begin
                        state <= SCALE;
                    end
                end
                SCALE: begin
                    memOut       <= {{16{yWord[15]}}, yWord};
                    memWriteAddr <= Y_ADDR + iIdx;
                    state        <= WRITE;
                end
                WRITE: begin
                    if (iIdx < I_LAST) begin
                        iIdx        <= iIdx + 11'd1;
                        jIdx        <= '0;
                        acc         <= '0;
                        memReadAddr <= A_ADDR;
                        state       <= RD_A;
                    end else begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign memWriteEn = (state == WRITE);
    assign done       = (state == DONE);

    // The sample arrives on memIn in the same cycle it must be multiplied,
    // so operand B passes straight through while in MAC; all operands are
    // forced to zero elsewhere so the L_mac sees quiet inputs.
    always_comb begin
        L_macOutA = '0;
        L_macOutB = '0;
        L_macOutC = '0;
        if (state == MAC) begin
            L_macOutA = aReg;
            L_macOutB = memIn[15:0];
            L_macOutC = (jIdx == 11'd0) ? 32'h0 : acc;
        end
    end

endmodule

// File: tb/tb_residu.sv
module tb_residu;

    localparam int M = 10;
    localparam int L = 40;
    localparam int A_BASE = 0;
    localparam int X_BASE = 64;
    localparam int Y_BASE = 128;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] memIn;
    logic [10:0] memReadAddr;
    logic        memWriteEn;
    logic [10:0] memWriteAddr;
    logic [31:0] memOut;
    logic        done;
    logic [15:0] L_macOutA;
    logic [15:0] L_macOutB;
    logic [31:0] L_macOutC;
    logic [31:0] L_macIn;

    int nChecks = 0;
    int nPass   = 0;

    logic [31:0] mem [0:2047];
    int coef [0:M];
    int xs   [0:L+M-1];     // x[k] stored at xs[k+M]
    int yExp [0:L-1];
    logic [31:0] wData [0:L-1];

    residu dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .memIn        (memIn),
        .memReadAddr  (memReadAddr),
        .memWriteEn   (memWriteEn),
        .memWriteAddr (memWriteAddr),
        .memOut       (memOut),
        .done         (done),
        .L_macOutA    (L_macOutA),
        .L_macOutB    (L_macOutB),
        .L_macOutC    (L_macOutC),
        .L_macIn      (L_macIn)
    );

    always #5 clk = ~clk;

    always @(posedge clk) memIn <= mem[memReadAddr];

    function automatic longint sat32(longint v);
        if (v > 64'sd2147483647)  return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
    endfunction

    // External saturating L_mac: C + 2*A*B
    always_comb begin
        L_macIn = 32'(sat32(longint'($signed(L_macOutC))
                  + 2 * longint'($signed(L_macOutA)) * longint'($signed(L_macOutB))));
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference: straight from the filter equation with G.729 saturation.
    task automatic computeModel();
        for (int i = 0; i < L; i++) begin
            longint acc = 0;
            longint s;
            longint r;
            for (int j = 0; j <= M; j++)
                acc = sat32(acc + 2 * longint'(coef[j]) * longint'(xs[i - j + M]));
            s = sat32(acc * 8);
            r = sat32(s + 32768);
            yExp[i] = int'(r >>> 16);
        end
    endtask

    task automatic loadMem();
        for (int k = 0; k < 2048; k++) mem[k] = $urandom;
        for (int j = 0; j <= M; j++)
            mem[A_BASE + j] = {16'($urandom), 16'(coef[j])};
        for (int k = -M; k < L; k++)
            mem[X_BASE + k] = {16'($urandom), 16'(xs[k + M])};
    endtask

    task automatic setIdentity();
        for (int j = 0; j <= M; j++) coef[j] = 0;
        coef[0] = 4096;
        for (int k = -M; k < L; k++) xs[k + M] = (k < 0) ? int'($urandom_range(0, 200)) - 100 : k + 1;
    endtask

    task automatic setRandom();
        for (int j = 0; j <= M; j++) coef[j] = int'($signed(16'($urandom))) >>> $urandom_range(0, 4);
        for (int k = 0; k < L + M; k++) xs[k] = int'($signed(16'($urandom))) >>> $urandom_range(0, 5);
    endtask

    // Start sampled at the posedge following this task's first negedge (cycle 0).
    task automatic pulseStart();
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic runTest(input string name, input bit noisyStart);
        int nW = 0;
        int firstW = -1;
        int firstA = -1;
        int lastA = -1;
        int doneC = -1;
        int doneN = 0;
        computeModel();
        loadMem();
        pulseStart();
        for (int c = 1; c <= 1500; c++) begin
            @(negedge clk);
            start = (noisyStart && c >= 2 && c <= 1300) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (memWriteEn) begin
                if (nW < L) begin
                    wData[nW] = memOut;
                    check($sformatf("%s y[%0d]", name, nW), memOut, 32'(yExp[nW]));
                end
                if (nW == 0) begin
                    firstW = c;
                    firstA = int'(memWriteAddr);
                end
                lastA = int'(memWriteAddr);
                nW++;
            end
            if (done) begin
                doneN++;
                if (doneC < 0) doneC = c;
            end
            if (doneC > 0 && c > doneC + 3) break;
        end
        start = 1'b0;
        check({name, " firstWriteCycle"}, 32'(firstW), 32'd35);
        check({name, " firstWriteAddr"}, 32'(firstA), 32'(Y_BASE));
        check({name, " writeCount"}, 32'(nW), 32'(L));
        check({name, " lastWriteAddr"}, 32'(lastA), 32'(Y_BASE + L - 1));
        check({name, " doneCycle"}, 32'(doneC), 32'd1401);
        check({name, " doneCount"}, 32'(doneN), 32'd1);
    endtask

    task automatic checkOutputsZero(input string name);
        check({name, " memReadAddr"}, 32'(memReadAddr), 32'd0);
        check({name, " memWriteEn"}, 32'(memWriteEn), 32'd0);
        check({name, " memWriteAddr"}, 32'(memWriteAddr), 32'd0);
        check({name, " memOut"}, memOut, 32'd0);
        check({name, " done"}, 32'(done), 32'd0);
        check({name, " macA"}, 32'(L_macOutA), 32'd0);
        check({name, " macB"}, 32'(L_macOutB), 32'd0);
        check({name, " macC"}, L_macOutC, 32'd0);
    endtask

    initial begin
        int strays;
        reset = 1'b0;
        start = 1'b0;
        for (int k = 0; k < 2048; k++) mem[k] = '0;
        #1 checkOutputsZero("reset");
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        repeat (2) @(posedge clk);

        setIdentity();
        runTest("identity", 1'b0);

        for (int j = 0; j <= M; j++) coef[j] = 0;
        coef[0] = 4096;
        coef[1] = -4096;
        for (int k = 0; k < L + M; k++) xs[k] = int'($urandom_range(0, 2000)) - 1000;
        xs[M - 1] = 5;
        xs[M]     = 7;
        xs[M + 1] = 4;
        runTest("diff", 1'b0);
        check("diff y0 literal", wData[0], 32'h0000_0002);
        check("diff y1 literal", wData[1], 32'hFFFF_FFFD);

        for (int j = 0; j <= M; j++) coef[j] = 0;
        coef[0] = 32767;
        coef[1] = 32767;
        for (int k = 0; k < L + M; k++) xs[k] = 32767;
        runTest("possat", 1'b0);
        check("possat y39 literal", wData[L - 1], 32'h0000_7FFF);

        for (int j = 0; j <= M; j++) coef[j] = 0;
        coef[0] = 32767;
        for (int k = 0; k < L + M; k++) xs[k] = -32768;
        runTest("negsat", 1'b0);
        check("negsat y0 literal", wData[0], 32'hFFFF_8000);

        for (int t = 0; t < 3; t++) begin
            setRandom();
            runTest($sformatf("rand%0d", t), t != 0);
        end

        // Abort mid-run, then rerun identity.
        setIdentity();
        computeModel();
        loadMem();
        pulseStart();
        repeat (199) @(posedge clk);
        #2 reset = 1'b0;
        #1 checkOutputsZero("abort");
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        strays = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (memWriteEn || done) strays++;
        end
        check("abort strayActivity", 32'(strays), 32'd0);
        runTest("rerun", 1'b0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/residu.md
RESIDU -- requirements
Module: residu

Interface
REQ-001 The block SHALL have parameters (name, default, meaning): M, 10, LPC order (taps 0..M); L, 40, subframe length in samples; A_ADDR, 11'd0, base of coefficients a[0..M]; X_ADDR, 11'd64, address of x[0], with history x[-M..-1] at X_ADDR-M..X_ADDR-1; Y_ADDR, 11'd128, base of output y[0..L-1].
REQ-002 Ports (name, direction, width, meaning): clk input 1, sole clock, rising edge.
REQ-003 reset input 1, asynchronous, active-low.
REQ-004 start input 1, level request sampled only in IDLE.
REQ-005 memIn input 32, read data; bits [15:0] hold a signed Q-format word, valid the cycle after memReadAddr is presented.
REQ-006 memReadAddr output 11, read address.
REQ-007 memWriteEn output 1, write strobe.
REQ-008 memWriteAddr output 11, write address.
REQ-009 memOut output 32, write data, sign-extended 16-bit y[i].
REQ-010 done output 1, one-cycle completion pulse.
REQ-011 L_macOutA output 16, coefficient operand a[j] to the external saturating L_mac.
REQ-012 L_macOutB output 16, sample operand x[i-j].
REQ-013 L_macOutC output 32, accumulator operand.
REQ-014 L_macIn input 32, combinational L_mac result, C + 2*A*B saturated.

Function
REQ-015 The block SHALL compute y[i] = round(L_shl(a[0]*x[i] + sum over j=1..M of a[j]*x[i-j], 3)) for i = 0..L-1, in G.729 fixed-point semantics.
REQ-016 FSM states SHALL be IDLE, RD_A, RD_X, MAC, SCALE, WRITE, DONE.
REQ-017 IDLE with start=1 SHALL go to RD_A with i=0, j=0, acc=0; otherwise it stays in IDLE.
REQ-018 RD_A SHALL drive memReadAddr=A_ADDR+j and go to RD_X.
REQ-019 RD_X SHALL latch memIn[15:0] as a, drive memReadAddr=X_ADDR+i-j (11-bit wrap) and go to MAC.
REQ-020 MAC SHALL latch memIn[15:0] as x and drive A=a, B=x, C=acc (C=0 when j=0) to L_mac.
REQ-021 At the MAC clock edge, acc SHALL take L_macIn; if j<M, j increments and the FSM goes to RD_A; otherwise it goes to SCALE.
REQ-022 SCALE SHALL shift acc left 3 with saturation (0x7FFFFFFF if positive overflow, 0x80000000 if negative), then round: add 0x00008000 with saturation and take bits [31:16].
REQ-023 WRITE SHALL assert memWriteEn for exactly one cycle, with memWriteAddr=Y_ADDR+i and memOut = the 16-bit result sign-extended.
REQ-024 After WRITE, if i<L-1, i SHALL increment, j and acc SHALL clear, and the FSM goes to RD_A; otherwise it goes to DONE.
REQ-025 DONE SHALL assert done for one cycle and return to IDLE; start still high in the next IDLE cycle restarts the block.
REQ-026 Latency SHALL be 3*(M+1)+2 = 35 cycles per sample and 1400 cycles from the start-sampling edge to the last write; done is high in cycle 1401.
REQ-027 The block SHALL ignore start outside IDLE.
REQ-028 The block SHALL never write to memory outside WRITE.
REQ-029 All outputs SHALL be registered or decoded from state only; none SHALL depend combinationally on start.

Reset
REQ-030 While reset=0, the FSM SHALL be in IDLE, with i, j, acc, memReadAddr, memWriteEn, memWriteAddr, memOut, done and L_macOutA/B/C all at 0, taking effect immediately and asynchronously.
REQ-031 Reset asserted mid-operation SHALL abort the run with no further writes; after release the block waits in IDLE for a new start.

Verification
REQ-032 Identity: a[0]=4096, a[1..10]=0, x[i]=i+1 -> y[i]=i+1 for all 40 samples, memOut[31:16]=0.
REQ-033 Difference: a[0]=4096, a[1]=-4096, others 0, x[-1]=5, x[0]=7, x[1]=4 -> y[0]=2, y[1]=0xFFFFFFFD (-3).
REQ-034 Positive saturation: a[0]=a[1]=32767, x all 32767 -> every memOut=0x00007FFF.
REQ-035 Negative saturation: a[0]=32767, others 0, x all -32768 -> every memOut=0xFFFF8000.
REQ-036 Timing: 1-cycle start pulse -> first memWriteEn in cycle 35 with memWriteAddr=128, 40 strobes total, last at address 167, done high for exactly cycle 1401.
REQ-037 Reset abort: reset=0 at cycle 200 -> outputs 0 in the same cycle, no writes until a new start; a rerun produces results identical to REQ-032.
